// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store.
// Data wins ties; a saturating starvation counter forces fetch after STARVE_MAX data grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [1:0] LAT_LOAD   = 2'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_q;
    logic              owner_q;      // 1 = data path, 0 = fetch
    logic              we_q;
    logic [1:0]        lat_q;
    logic [3:0]        starve_q;
    logic              grant_data_d;

    logic [DATA_W-1:0] if_rdata_q, d_rdata_q, mem_wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              if_ack_q, d_ack_q, mem_en_q, mem_we_q, busy_q;

    always_comb begin
        grant_data_d = d_req && (!if_req || (starve_q < STARVE_LIM));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            lat_q       <= '0;
            starve_q    <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!if_req) starve_q <= '0;
                    if (d_req || if_req) begin
                        // Request fields are latched straight into the port registers
                        // so the strobe appears with them in the ISSUE cycle.
                        state_q  <= S_ISSUE;
                        busy_q   <= 1'b1;
                        mem_en_q <= 1'b1;
                        owner_q  <= grant_data_d;
                        if (grant_data_d) begin
                            we_q        <= d_we;
                            mem_we_q    <= d_we;
                            mem_addr_q  <= d_addr;
                            mem_wdata_q <= d_wdata;
                            if (if_req && (starve_q != 4'hF)) starve_q <= starve_q + 4'd1;
                        end else begin
                            we_q        <= 1'b0;
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= '0;
                            starve_q    <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    lat_q   <= LAT_LOAD;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (lat_q == 2'd0) begin
                        state_q <= S_RESP;
                        if (owner_q) begin
                            d_ack_q <= 1'b1;
                            if (!we_q) d_rdata_q <= mem_rdata;
                        end else begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= mem_rdata;
                        end
                    end else begin
                        lat_q <= lat_q - 2'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_ack     = d_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences and shares the single memory port between two requesters: the instruction-fetch path (read-only) and the load/store data path. It serialises accesses with a req/ack handshake and a fixed-latency memory model. Data accesses win ties, and a starvation counter bounds how long fetch can wait. It sits between the core datapath and the memory block so that the fetch and load/store paths no longer need separate memory ports.

Parameters:
ADDR_W, 32, address width of requesters and memory port
DATA_W, 32, data width
MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..4
STARVE_MAX, 2, consecutive data grants allowed while if_req is pending before fetch is forced; legal range 1..15

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-high
if_req  input  1  fetch request; held high until if_ack
if_addr  input  ADDR_W  fetch byte address; stable while if_req is high
if_rdata  output  DATA_W  fetched word; valid in the if_ack cycle, holds until the next fetch ack
if_ack  output  1  one-cycle completion pulse for fetch
d_req  input  1  data request; held high until d_ack
d_we  input  1  1 = store, 0 = load; stable while d_req is high
d_addr  input  ADDR_W  data byte address
d_wdata  input  DATA_W  store data
d_rdata  output  DATA_W  load data; valid in the d_ack cycle, holds until the next data ack
d_ack  output  1  one-cycle completion pulse for data
mem_en  output  1  memory access strobe, one cycle per transaction
mem_we  output  1  memory write strobe; only ever high together with mem_en
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
busy  output  1  high whenever state is not IDLE

Behaviour:
- All outputs are registered.
- Reset (async, any state): state=IDLE; every output=0; owner=0; latency counter=0; starve_cnt=0. Any in-flight memory response is discarded and no ack is issued for it.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE (cycle T):
  - No request: stay in IDLE.
  - Requests present: pick an owner; capture address, we and wdata into registers; go to ISSUE.
  - Grant rule: if d_req=1 and (if_req=0 or starve_cnt<STARVE_MAX), grant data; otherwise if if_req=1, grant fetch.
- ISSUE (cycle T+1):
  - mem_en=1; mem_addr, mem_we and mem_wdata come from the captured values.
  - For a fetch, mem_we=0 and mem_wdata=0.
  - Load the latency counter with MEM_LAT-1; go to WAIT.
- WAIT (cycles T+2 .. T+1+MEM_LAT):
  - mem_en=0 and mem_we=0.
  - Decrement the counter each cycle.
  - In the cycle where the counter reads 0 (T+1+MEM_LAT), capture mem_rdata into the owner's rdata register and go to RESP.
  - Stores wait for the same latency; d_rdata is not updated on a store.
- RESP (cycle T+2+MEM_LAT):
  - The owner's ack=1 for exactly this cycle.
  - Requests are ignored in RESP; go to IDLE.
  - A requester may hold req high into the next cycle with a new address, which is treated as a new transaction.
- Timing: request-to-ack latency is MEM_LAT+2 cycles. Peak throughput is one transaction per MEM_LAT+3 cycles.
- Starvation counter:
  - Incremented (saturating at 15) on each data grant made while if_req=1.
  - Cleared on any fetch grant.
  - Cleared in IDLE when if_req=0.
- A req dropped before its ack does not abort the transaction. The ack still pulses and the requester discards it.
- Requester inputs are sampled only in IDLE; changes after that point have no effect on the transaction in flight.
- if_ack and d_ack are never high in the same cycle.
- mem_en is never high outside ISSUE.

Test Plan:
- Reset mid-WAIT (MEM_LAT=3, data load in flight), rst pulsed asynchronously -> all outputs 0 immediately, no d_ack; a following if_req at addr 0x8 completes normally with if_ack 5 cycles later.
- Single fetch, MEM_LAT=1: if_req with if_addr=0x10 at T, memory returns 0xDEADBEEF -> mem_en=1 with mem_addr=0x10 only at T+1; if_ack=1 and if_rdata=0xDEADBEEF at T+3; busy high T+1..T+3.
- Store: d_req, d_we=1, d_addr=0x40, d_wdata=0x1234 at T -> mem_en=mem_we=1, mem_addr=0x40, mem_wdata=0x1234 at T+1; d_ack at T+3; d_rdata unchanged; if_ack stays 0.
- Simultaneous if_req and d_req (load 0x20, fetch 0x0) at T -> data granted first with d_ack at T+3; fetch granted in IDLE at T+4; if_ack at T+7.
- Starvation, STARVE_MAX=2: d_req and if_req held continuously -> grant order D,D,I,D,D,I observed on mem_en cycles; never more than 2 consecutive data grants.
- MEM_LAT=4 build: fetch at T -> mem_en at T+1, rdata captured at T+5, if_ack at T+6; back-to-back fetch with req held -> second mem_en at T+8.
